// File: rtl/la_test_sequencer.sv
// LA-driven test sequencer: reads N_WORDS words from firmware, transforms them, and returns
// the results under an ack/timeout handshake while publishing status codes on user GPIO.
module la_test_sequencer #(
    parameter int N_WORDS = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        start_i,
    input  logic        finish_i,
    input  logic [7:0]  test_id_i,
    input  logic [31:0] data_in_i,
    input  logic        data_in_valid_i,
    output logic        data_in_ready_o,
    output logic [31:0] data_out_o,
    output logic        data_out_valid_o,
    input  logic        data_out_ack_i,
    output logic [15:0] status_o,
    output logic [7:0]  id_o,
    output logic [23:0] io_oeb_o
);

    localparam int IW = $clog2(N_WORDS);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(N_WORDS - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_READ   = 3'd2;
    localparam logic [2:0] S_PROC   = 3'd3;
    localparam logic [2:0] S_WRITE  = 3'd4;
    localparam logic [2:0] S_PASS   = 3'd5;
    localparam logic [2:0] S_FAIL   = 3'd6;
    localparam logic [2:0] S_FINISH = 3'd7;

    logic [2:0]    state;
    logic [IW-1:0] idx;
    logic [CW-1:0] cnt;
    logic [31:0]   data_buf [N_WORDS];
    logic [31:0]   res_buf  [N_WORDS];

    function automatic logic [15:0] status_of(input logic [2:0] s);
        case (s)
            S_START:  return 16'hAB40;
            S_READ:   return 16'hAB41;
            S_PROC:   return 16'hAB42;
            S_WRITE:  return 16'hAB51;
            S_PASS:   return 16'hAB43;
            S_FAIL:   return 16'hAB44;
            S_FINISH: return 16'hABFF;
            default:  return 16'h0000;
        endcase
    endfunction

    function automatic logic [31:0] rotl1(input logic [31:0] w);
        return {w[30:0], w[31]};
    endfunction

    assign io_oeb_o = '0;

    // status_o is written together with every state change so it reflects the entered state
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state            <= S_IDLE;
            status_o         <= 16'h0000;
            id_o             <= 8'h00;
            idx              <= '0;
            cnt              <= '0;
            data_in_ready_o  <= 1'b0;
            data_out_valid_o <= 1'b0;
            data_out_o       <= '0;
            for (int i = 0; i < N_WORDS; i++) begin
                data_buf[i] <= '0;
                res_buf[i]  <= '0;
            end
        end else begin
            case (state)
                S_IDLE, S_PASS, S_FAIL: begin
                    if (finish_i) begin
                        state    <= S_FINISH;
                        status_o <= status_of(S_FINISH);
                    end else if (start_i) begin
                        state    <= S_START;
                        status_o <= status_of(S_START);
                        id_o     <= test_id_i;
                    end
                end
                S_START: begin
                    idx             <= '0;
                    data_in_ready_o <= 1'b1;
                    state           <= S_READ;
                    status_o        <= status_of(S_READ);
                end
                S_READ: begin
                    if (data_in_valid_i) begin
                        data_buf[idx] <= data_in_i;
                        if (idx == LAST_IDX) begin
                            idx             <= '0;
                            data_in_ready_o <= 1'b0;
                            state           <= S_PROC;
                            status_o        <= status_of(S_PROC);
                        end else begin
                            idx <= idx + IW'(1);
                        end
                    end
                end
                S_PROC: begin
                    // Index wraps naturally because N_WORDS is a power of two
                    res_buf[idx] <= rotl1(data_buf[idx]) ^ data_buf[idx + IW'(1)];
                    if (idx == LAST_IDX) begin
                        idx              <= '0;
                        cnt              <= '0;
                        data_out_valid_o <= 1'b1;
                        data_out_o       <= res_buf[0];
                        state            <= S_WRITE;
                        status_o         <= status_of(S_WRITE);
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                S_WRITE: begin
                    if (data_out_ack_i) begin
                        cnt <= '0;
                        if (idx == LAST_IDX) begin
                            data_out_valid_o <= 1'b0;
                            data_out_o       <= '0;
                            state            <= S_PASS;
                            status_o         <= status_of(S_PASS);
                        end else begin
                            idx        <= idx + IW'(1);
                            data_out_o <= res_buf[idx + IW'(1)];
                        end
                    end else if (cnt == CNT_LAST) begin
                        data_out_valid_o <= 1'b0;
                        data_out_o       <= '0;
                        state            <= S_FAIL;
                        status_o         <= status_of(S_FAIL);
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_la_test_sequencer.sv
// Directed + randomized bench for la_test_sequencer with a rule-level result model.
module tb_la_test_sequencer;

    localparam int N  = 4;
    localparam int TO = 16;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic        start_i;
    logic        finish_i;
    logic [7:0]  test_id_i;
    logic [31:0] data_in_i;
    logic        data_in_valid_i;
    logic        data_in_ready_o;
    logic [31:0] data_out_o;
    logic        data_out_valid_o;
    logic        data_out_ack_i;
    logic [15:0] status_o;
    logic [7:0]  id_o;
    logic [23:0] io_oeb_o;

    int total  = 0;
    int passed = 0;
    int fails  = 0;

    logic [31:0] words   [N];
    logic [31:0] exp_res [N];

    la_test_sequencer #(.N_WORDS(N), .TIMEOUT(TO)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .start_i(start_i), .finish_i(finish_i),
        .test_id_i(test_id_i), .data_in_i(data_in_i), .data_in_valid_i(data_in_valid_i),
        .data_in_ready_o(data_in_ready_o), .data_out_o(data_out_o),
        .data_out_valid_o(data_out_valid_o), .data_out_ack_i(data_out_ack_i),
        .status_o(status_o), .id_o(id_o), .io_oeb_o(io_oeb_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Reference: each result is the word rotated left by one, XORed with the next word (cyclic)
    task automatic build_model();
        logic [31:0] w;
        for (int i = 0; i < N; i++) begin
            w = words[i];
            exp_res[i] = ((w << 1) | (w >> 31)) ^ words[(i + 1) % N];
        end
    endtask

    task automatic run_test(input logic [7:0] id, input int gap, input int ack_max,
                            input bit timeout_mode, input bit rst_in_proc);
        int got;
        int d;
        bit acc;
        build_model();
        test_id_i = id;
        start_i   = 1'b1;
        step();
        check("start_status", 32'(status_o), 32'hAB40);
        check("start_id", 32'(id_o), 32'(id));
        start_i   = 1'b0;
        test_id_i = 8'($urandom);
        step();
        check("read_status", 32'(status_o), 32'hAB41);
        check("read_ready", 32'(data_in_ready_o), 32'd1);
        got = 0;
        for (int c = 0; c < 200 && got < N; c++) begin
            data_in_valid_i = ((c % gap) == 0);
            data_in_i = data_in_valid_i ? words[got] : 32'($urandom);
            acc = data_in_valid_i && data_in_ready_o;
            step();
            if (acc) got++;
            if (got < N) check("read_hold", 32'(status_o), 32'hAB41);
        end
        data_in_valid_i = 1'b0;
        check("read_done", 32'(got), 32'(N));
        check("proc_status", 32'(status_o), 32'hAB42);
        check("proc_ready", 32'(data_in_ready_o), 32'd0);
        if (rst_in_proc) begin
            wb_rst_i = 1'b1;
            step();
            check("mrst_status", 32'(status_o), 32'h0);
            check("mrst_id", 32'(id_o), 32'h0);
            check("mrst_ready", 32'(data_in_ready_o), 32'd0);
            check("mrst_valid", 32'(data_out_valid_o), 32'd0);
            check("mrst_dout", data_out_o, 32'h0);
            wb_rst_i = 1'b0;
            return;
        end
        for (int k = 1; k < N; k++) begin
            step();
            check("proc_len", 32'(status_o), 32'hAB42);
        end
        step();
        check("write_status", 32'(status_o), 32'hAB51);
        check("write_valid", 32'(data_out_valid_o), 32'd1);
        if (timeout_mode) begin
            check("to_word0", data_out_o, exp_res[0]);
            data_out_ack_i = 1'b1;
            step();
            data_out_ack_i = 1'b0;
            for (int c = 1; c < TO; c++) begin
                step();
                check("to_wait_status", 32'(status_o), 32'hAB51);
                check("to_wait_word", data_out_o, exp_res[1]);
            end
            step();
            check("to_fail_status", 32'(status_o), 32'hAB44);
            check("to_fail_valid", 32'(data_out_valid_o), 32'd0);
            return;
        end
        for (int i = 0; i < N; i++) begin
            d = $urandom_range(ack_max, 0);
            for (int h = 0; h < d; h++) begin
                check("ack_hold_word", data_out_o, exp_res[i]);
                step();
            end
            check("out_word", data_out_o, exp_res[i]);
            check("out_valid", 32'(data_out_valid_o), 32'd1);
            data_out_ack_i = 1'b1;
            step();
            data_out_ack_i = 1'b0;
        end
        check("pass_status", 32'(status_o), 32'hAB43);
        check("pass_valid", 32'(data_out_valid_o), 32'd0);
    endtask

    initial begin
        wb_rst_i = 1'b1; start_i = 1'b0; finish_i = 1'b0; test_id_i = 8'h00;
        data_in_i = 32'h0; data_in_valid_i = 1'b0; data_out_ack_i = 1'b0;
        for (int i = 0; i < 5; i++) step();
        wb_rst_i = 1'b0;
        step();
        check("rst_status", 32'(status_o), 32'h0);
        check("rst_id", 32'(id_o), 32'h0);
        check("rst_oeb", 32'(io_oeb_o), 32'h0);
        check("rst_ready", 32'(data_in_ready_o), 32'd0);
        check("rst_valid", 32'(data_out_valid_o), 32'd0);
        check("rst_dout", data_out_o, 32'h0);
        for (int i = 0; i < 100; i++) begin
            step();
            check("idle_hold", {status_o, id_o, 7'd0, data_out_valid_o}, 32'h0);
        end

        // Full pass with fixed words and immediate acks
        words[0] = 32'h00000001; words[1] = 32'h00000002;
        words[2] = 32'h80000000; words[3] = 32'hFFFFFFFF;
        run_test(8'h01, 1, 0, 1'b0, 1'b0);

        // Back-to-back from PASS with sparse input
        for (int i = 0; i < N; i++) words[i] = $urandom;
        run_test(8'h02, 3, 0, 1'b0, 1'b0);

        // Ack timeout after the first word
        words[0] = 32'h00000001; words[1] = 32'h00000002;
        words[2] = 32'h80000000; words[3] = 32'hFFFFFFFF;
        run_test(8'h01, 1, 0, 1'b1, 1'b0);

        // Random tests with random input gaps and ack delays
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < N; i++) words[i] = $urandom;
            run_test(8'($urandom), int'($urandom_range(3, 1)), 5, 1'b0, 1'b0);
        end

        // Mid-operation reset in PROC, then a clean test
        for (int i = 0; i < N; i++) words[i] = $urandom;
        run_test(8'h05, 1, 0, 1'b0, 1'b1);
        for (int i = 0; i < N; i++) words[i] = $urandom;
        run_test(8'h06, 2, 2, 1'b0, 1'b0);

        // Finish precedence and stickiness
        wb_rst_i = 1'b1;
        step();
        wb_rst_i = 1'b0;
        start_i = 1'b1; finish_i = 1'b1; test_id_i = 8'h33;
        step();
        check("finish_status", 32'(status_o), 32'hABFF);
        check("finish_id", 32'(id_o), 32'h0);
        finish_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            data_in_valid_i = 1'($urandom);
            data_out_ack_i  = 1'($urandom);
            step();
            check("finish_sticky", 32'(status_o), 32'hABFF);
            check("finish_ready", 32'(data_in_ready_o), 32'd0);
        end
        start_i = 1'b0; data_in_valid_i = 1'b0; data_out_ack_i = 1'b0;
        wb_rst_i = 1'b1;
        step();
        check("finish_rst", 32'(status_o), 32'h0);
        wb_rst_i = 1'b0;
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
